// File: rtl/scig_cif_mul_arbiter_if.sv
// Bus bundle between the multiplier arbiter, its requesters,
// its response consumer and the shared multiplier.
interface scig_cif_mul_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_a;
   logic [NUM_REQ*16-1:0] req_b;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [ID_W-1:0]       resp_id;
   logic [31:0]           resp_data;
   logic                  mul_ce;
   logic [31:0]           mul_din0;
   logic [15:0]           mul_din1;
   logic [31:0]           mul_dout;
   logic                  busy;

   modport master (
      input  req_valid, req_a, req_b,
      input  resp_ready, mul_dout,
      output req_ready, resp_valid,
      output resp_id, resp_data,
      output mul_ce, mul_din0, mul_din1,
      output busy
   );

   modport slave (
      output req_valid, req_a, req_b,
      output resp_ready, mul_dout,
      input  req_ready, resp_valid,
      input  resp_id, resp_data,
      input  mul_ce, mul_din0, mul_din1,
      input  busy
   );
endinterface

// File: rtl/scig_cif_mul_arbiter.sv
// Round-robin sharing of one pipelined 32sx16u multiplier;
// a tag pipe tracks owners, whole pipe stalls via mul_ce.
module scig_cif_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int MUL_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   scig_cif_mul_arbiter_if.master bus
);
   localparam logic [ID_W:0] NREQ =
      (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST =
      ID_W'(NUM_REQ - 1);

   logic                  adv;
   logic                  gnt_any;
   logic                  grant;
   logic [ID_W-1:0]       gnt_id;
   logic [ID_W:0]         sum;
   logic [ID_W-1:0]       idx;
   logic [ID_W-1:0]       rr_ptr_q;
   logic [ID_W-1:0]       rr_ptr_d;
   logic [MUL_LATENCY-1:0] tag_v_q;
   logic [ID_W-1:0]       tag_id_q [MUL_LATENCY];
   logic                  resp_valid_q;
   logic [ID_W-1:0]       resp_id_q;
   logic [31:0]           resp_data_q;

   assign adv = !reset &&
      (!resp_valid_q || bus.resp_ready);

   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (sum >= NREQ) sum = sum - NREQ;
         idx = sum[ID_W-1:0];
         if (!gnt_any && bus.req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = idx;
         end
      end
   end

   assign grant = adv && gnt_any;

   always_comb begin
      bus.req_ready = '0;
      bus.mul_din0  = '0;
      bus.mul_din1  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant && gnt_id == ID_W'(k)) begin
            bus.req_ready[k] = 1'b1;
            bus.mul_din0 = bus.req_a[k*32 +: 32];
            bus.mul_din1 = bus.req_b[k*16 +: 16];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant)
         rr_ptr_d = (gnt_id == LAST) ?
            '0 : gnt_id + 1'b1;
   end

   // Tags and output register advance in lockstep with mul_ce
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q     <= '0;
         tag_v_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_data_q  <= '0;
         for (int i = 0; i < MUL_LATENCY; i++)
            tag_id_q[i] <= '0;
      end else if (adv) begin
         rr_ptr_q    <= rr_ptr_d;
         tag_v_q[0]  <= grant;
         tag_id_q[0] <= gnt_id;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
         resp_valid_q <= tag_v_q[MUL_LATENCY-1];
         resp_id_q    <= tag_id_q[MUL_LATENCY-1];
         resp_data_q  <= bus.mul_dout;
      end
   end

   assign bus.mul_ce     = adv;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.busy       = !reset &&
      ((|tag_v_q) || resp_valid_q);
endmodule
